// File: rtl/pollard_pkg.sv
// Shared widths, FSM encoding and constants for the exponentiation job driver.
package pollard_pkg;

    localparam int unsigned BASE_W = 9;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned RES_W  = 100;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSettle,
        StWait,
        StHold
    } state_e;

    localparam logic [RES_W-1:0] RESULT_ONE = RES_W'(1);

endpackage

// File: rtl/exp_job_driver_if.sv
// Job, core and result channels of the exponentiation job driver.
interface exp_job_driver_if;
    import pollard_pkg::*;

    logic              job_valid;
    logic              job_ready;
    logic [BASE_W-1:0] job_base;
    logic [EXP_W-1:0]  job_exp;

    logic [BASE_W-1:0] exp_base;
    logic [EXP_W-1:0]  exp_exponent;
    logic              exp_reset;
    logic [RES_W-1:0]  exp_result;
    logic              exp_isDone;

    logic              res_valid;
    logic              res_ready;
    logic [RES_W-1:0]  res_data;
    logic              res_timeout;

    logic              busy;

    // master is the driver itself; slave is the surrounding sequencer and core
    modport master (
        input  job_valid, job_base, job_exp, exp_result, exp_isDone, res_ready,
        output job_ready, exp_base, exp_exponent, exp_reset, res_valid, res_data,
               res_timeout, busy
    );

    modport slave (
        output job_valid, job_base, job_exp, exp_result, exp_isDone, res_ready,
        input  job_ready, exp_base, exp_exponent, exp_reset, res_valid, res_data,
               res_timeout, busy
    );

endinterface

// File: rtl/exp_job_driver.sv
// Initiator for the BinaryExponentiation core: accepts a job, restarts the core,
// waits for completion (with timeout) and holds the result until taken.
module exp_job_driver
    import pollard_pkg::*;
#(
    parameter int unsigned RESTART_CYCLES = 2,
    parameter int unsigned TIMEOUT        = 1023
) (
    input  logic             clk,
    input  logic             reset,
    exp_job_driver_if.master bus
);

    localparam int unsigned RW = $clog2(RESTART_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [RW-1:0]     rst_cnt_q, rst_cnt_d;
    logic [TW-1:0]     to_cnt_q, to_cnt_d;
    logic [BASE_W-1:0] base_q, base_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [RES_W-1:0]  res_q, res_d;
    logic              timeout_q, timeout_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            rst_cnt_q <= '0;
            to_cnt_q  <= '0;
            base_q    <= '0;
            exp_q     <= '0;
            res_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            to_cnt_q  <= to_cnt_d;
            base_q    <= base_d;
            exp_q     <= exp_d;
            res_q     <= res_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        to_cnt_d  = to_cnt_q;
        base_d    = base_q;
        exp_d     = exp_q;
        res_d     = res_q;
        timeout_d = timeout_q;

        unique case (state_q)
            StIdle: begin
                if (bus.job_valid) begin
                    base_d    = bus.job_base;
                    exp_d     = bus.job_exp;
                    rst_cnt_d = '0;
                    // x^0 needs no core run
                    if (bus.job_exp == '0) begin
                        res_d     = RESULT_ONE;
                        timeout_d = 1'b0;
                        state_d   = StHold;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                rst_cnt_d = rst_cnt_q + RW'(1);
                if (rst_cnt_q == RW'(RESTART_CYCLES - 1)) begin
                    state_d = StSettle;
                end
            end
            StSettle: begin
                // isDone may still be high from the previous job here
                to_cnt_d = '0;
                state_d  = StWait;
            end
            StWait: begin
                to_cnt_d = to_cnt_q + TW'(1);
                if (bus.exp_isDone) begin
                    res_d     = bus.exp_result;
                    timeout_d = 1'b0;
                    state_d   = StHold;
                end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                    res_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = StHold;
                end
            end
            StHold: begin
                if (bus.res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Gated by reset so the port reads 0 while reset is held, 1 right after release
    assign bus.job_ready    = (state_q == StIdle) && reset;
    assign bus.busy         = (state_q != StIdle);
    assign bus.exp_reset    = (state_q == StLoad);
    assign bus.exp_base     = base_q;
    assign bus.exp_exponent = exp_q;
    assign bus.res_valid    = (state_q == StHold);
    assign bus.res_data     = res_q;
    assign bus.res_timeout  = timeout_q;

endmodule
